// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: queues execute-stage branch updates and drains them
// to the BTB write port, walking all entries with invalid writes after reset/flush.
module btb_update_ctrl #(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_upd_valid,
    output logic            io_upd_ready,
    input  logic [XLEN-1:0] io_upd_bits_pc,
    input  logic            io_upd_bits_jump,
    input  logic [XLEN-1:0] io_upd_bits_target,
    input  logic            io_flush,
    output logic            io_busy,
    output logic            io_rd_block,
    output logic            io_btb_w_en,
    output logic [XLEN-1:0] io_btb_w_pc,
    output logic            io_btb_w_valid,
    output logic            io_btb_w_jump,
    output logic [XLEN-1:0] io_btb_w_target
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic {S_CLEAR, S_IDLE} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            jump;
        logic [XLEN-1:0] target;
    } upd_t;

    typedef struct packed {
        logic            en;
        logic            valid;
        logic            jump;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } wr_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    wr_t              wr_q, wr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    upd_t             mem_q [DEPTH];

    logic            fifo_full, fifo_empty, push, pop;
    upd_t            head;
    logic [XLEN-1:0] clr_pc;

    assign fifo_full    = (cnt_q == CNT_FULL);
    assign fifo_empty   = (cnt_q == '0);
    assign io_upd_ready = !fifo_full && !io_flush && !reset;
    assign push         = io_upd_valid && io_upd_ready;
    assign head         = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        pop     = 1'b0;
        clr_pc  = '0;
        clr_pc[IDX_W+1:2] = idx_q;
        case (state_q)
            S_CLEAR: begin
                wr_d.en     = 1'b1;
                wr_d.valid  = 1'b0;
                wr_d.jump   = 1'b0;
                wr_d.pc     = clr_pc;
                wr_d.target = '0;
                idx_d       = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    wr_d.en     = 1'b1;
                    wr_d.valid  = 1'b1;
                    wr_d.jump   = head.jump;
                    wr_d.pc     = head.pc;
                    wr_d.target = head.target;
                end else begin
                    wr_d.en = 1'b0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        // The write loaded this cycle still goes out; the restarted walk overwrites it.
        if (io_flush) begin
            state_d = S_CLEAR;
            idx_d   = '0;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (io_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_CLEAR;
            idx_q    <= '0;
            wr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: io_upd_bits_pc, jump: io_upd_bits_jump,
                                 target: io_upd_bits_target};
        end
    end

    assign io_busy         = (state_q == S_CLEAR);
    assign io_rd_block     = io_busy || (wr_q.en && !wr_q.valid);
    assign io_btb_w_en     = wr_q.en;
    assign io_btb_w_pc     = wr_q.pc;
    assign io_btb_w_valid  = wr_q.valid;
    assign io_btb_w_jump   = wr_q.jump;
    assign io_btb_w_target = wr_q.target;

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Write-side controller for the branch target buffer (256 entries, 8-bit index = pc[9:2], tag = pc[31:10]). It buffers branch-resolution updates from the execute stage in a small FIFO and drains them onto the BTB write port. After reset and on every flush it walks all entries and writes invalid entries. While invalidation is in progress it tells fetch to ignore BTB hits.

Parameters:
IDX_W, 8, BTB index width; the clear walk covers 2^IDX_W entries.
DEPTH, 4, update FIFO depth (power of two, >=2).
XLEN, 32, pc/target width.

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
io_upd_valid  in  1  execute-stage update request
io_upd_ready  out  1  update accepted when valid&ready
io_upd_bits_pc  in  XLEN  branch pc
io_upd_bits_jump  in  1  resolved taken/jump flag
io_upd_bits_target  in  XLEN  resolved target
io_flush  in  1  invalidate-all request, sampled each cycle
io_busy  out  1  clear walk in progress
io_rd_block  out  1  fetch must treat BTB hit as miss
io_btb_w_en  out  1  BTB write enable
io_btb_w_pc  out  XLEN  write pc (index = [IDX_W+1:2], tag = upper bits)
io_btb_w_valid  out  1  entry valid bit written
io_btb_w_jump  out  1  entry jump bit
io_btb_w_target  out  XLEN  entry target

Behaviour:
- Reset is asynchronous and active-high. Reset state: state=CLEAR, idx=0, FIFO empty, write-port register all zero.
- Reset output values: io_btb_w_*=0, io_upd_ready=0, io_busy=1, io_rd_block=1.
- All io_btb_w_* outputs come from one output register. No combinational path from io_upd_* to the write port.
- States:
  - CLEAR: each cycle, load the output register with w_en=1, w_valid=0, w_jump=0, w_target=0, w_pc={0, idx, 2'b00}. Then idx++.
  - CLEAR exit: when idx = 2^IDX_W-1, go to IDLE and set idx to 0. The FIFO is not popped in CLEAR.
  - IDLE: if the FIFO is non-empty, pop the head into the output register with w_en=1 and w_valid=1. Otherwise load w_en=0. Throughput is one write per cycle.
- io_flush=1 in any state, in cycle f:
  - Next state is CLEAR with idx=0. A flush during CLEAR restarts the walk.
  - FIFO is emptied.
  - io_upd_ready=0 in cycle f, so no update is accepted in the flush cycle.
  - The output-register content loaded at the end of cycle f is still written. It is overwritten later by the walk.
- io_upd_ready = !fifo_full & !io_flush & !reset. Updates are accepted in both IDLE and CLEAR. Updates accepted during CLEAR drain after the walk completes.
- Full FIFO: ready is low. The FIFO never overflows. Pops and pushes in the same cycle are allowed. A push into a full FIFO is not allowed even if it pops that cycle.
- Update latency: handshake in cycle t with the FIFO empty and state IDLE gives io_btb_w_en=1 carrying that update in cycle t+2. FIFO order is preserved.
- io_busy = (state==CLEAR).
- io_rd_block = (state==CLEAR) | (io_btb_w_en & !io_btb_w_valid). It stays high until the last invalidating write has been presented.
- Post-reset timing (cycle 0 = first cycle with reset low):
  - State is CLEAR in cycles 0..255.
  - Clear writes for idx k appear in cycle k+1, covering cycles 1..256.
  - io_busy falls at cycle 256. io_rd_block falls at cycle 257.
  - The first queued update is written in cycle 257.
- Flush timing (flush in cycle f):
  - Clear writes appear in f+2..f+257.
  - io_rd_block is high in f+1..f+257.
- Reset asserted mid-operation: immediately returns to the reset state. FIFO contents are lost.

Test Plan:
- Reset release, no traffic:
  - io_btb_w_en=1 with w_valid=0 and w_pc = k<<2 in cycle k+1, for k=0..255.
  - io_rd_block low at cycle 257, io_busy low at cycle 256.
- IDLE, single update (pc=0x8000_1234, jump=1, target=0x8000_2000) in cycle t:
  - Cycle t+2: w_en=1, w_valid=1, w_pc=0x8000_1234, w_jump=1, w_target=0x8000_2000.
  - Cycle t+3: w_en=0.
- Five back-to-back updates while in CLEAR (DEPTH=4):
  - First four accepted, ready low on the fifth.
  - After the walk, the four are written in order in consecutive cycles 257..260. The fifth is then accepted.
- io_flush in cycle 100 of the post-reset walk:
  - Cycle 101: state CLEAR, idx=0.
  - Clear writes idx 0..255 in cycles 102..357.
  - io_rd_block continuously high 0..357.
- IDLE, three updates queued, then io_flush in the cycle the first would pop:
  - That first update is written in the next cycle.
  - The remaining two are discarded (never appear on the write port).
  - A full 256-entry walk follows.
- Update presented in the same cycle as io_flush: io_upd_ready=0, no write of that pc ever occurs. Re-presented next cycle, it is accepted and written after the walk.
